control_ventilador: RTL
=======================

# control_ventilador

Fan and over-temperature alarm controller directly downstream of the 5-bit temperature comparator. Consumes the comparator's `mayor25` / `mayor28` flags, debounces them over a configurable number of sample ticks and selects one of three fan levels. It drives a PWM fan output and raises a sticky alarm when the high level persists too long.

## Interface
- `DEB_N`, 4: consecutive consistent samples required before a level change (1..15).
- `ALARM_N`, 16: samples spent in HIGH before the alarm asserts (1..255).
- `PWM_BITS`, 4: PWM counter width; period = 2^PWM_BITS clocks.
- `DUTY_LOW`, 8: high-time in clocks per PWM period while in LOW (0..2^PWM_BITS).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `sample_en`  in  1  one-cycle sample strobe; flags are evaluated only when it is 1.
- `mayor25`  in  1  temperature > 25, from the comparator.
- `mayor28`  in  1  temperature > 28, from the comparator.
- `alarm_clr`  in  1  one-cycle alarm acknowledge.
- `fan_state`  out  2  current level: 0 = OFF, 1 = LOW, 2 = HIGH (3 is never driven).
- `fan_pwm`  out  1  fan drive.
- `alarm`  out  1  sticky over-temperature alarm.

## Operation
- **Target decode** (combinational, used only on `sample_en`):
  - `mayor28` = 1 → HIGH, regardless of `mayor25`. The combination 01 is illegal and treated as HIGH.
  - Otherwise `mayor25` = 1 → LOW.
  - Otherwise → OFF.
- **Debounce**, on each `sample_en` cycle. Registers: `cand` (2 bits), `cnt` (4 bits).
  - target == `fan_state`: `cnt` ← 0.
  - target != `fan_state` and target == `cand`: `cnt` ← `cnt` + 1.
  - target != `fan_state` and target != `cand`: `cand` ← target, `cnt` ← 1.
  - When the updated count equals `DEB_N`: `fan_state` ← target and `cnt` ← 0, in the same edge.
  - Any jump is legal, including OFF↔HIGH directly.
  - Without `sample_en`, `cand` and `cnt` hold.
- **Alarm counter** (8 bits), advanced on `sample_en`.
  - Increments while `fan_state` == HIGH, saturating at `ALARM_N`.
  - Cleared to 0 on the edge on which `fan_state` leaves HIGH.
  - `alarm` ← 1 on the edge on which the counter reaches `ALARM_N`.
  - `alarm` stays 1 after leaving HIGH; it clears only on `alarm_clr`.
  - `alarm_clr` clears both `alarm` and the counter. If `fan_state` is still HIGH, counting restarts from 0 on the next sample.
  - `alarm_clr` in the same cycle as a set condition: clear wins.
- **PWM**
  - Free-running `PWM_BITS` counter, increments every clock and wraps to 0.
  - OFF: `fan_pwm` = 0. LOW: `fan_pwm` = (counter < `DUTY_LOW`). HIGH: `fan_pwm` = 1.
  - `DUTY_LOW` = 0 gives constant 0 in LOW; `DUTY_LOW` = 2^PWM_BITS gives constant 1.
- **Reset** (while `rst_n` = 0): `fan_state` = 0, `cand` = 0, `cnt` = 0, alarm counter = 0, PWM counter = 0, `alarm` = 0, `fan_pwm` = 0. Reset mid-debounce or mid-alarm discards all progress.

## Timing
- `fan_state` changes on the edge that samples the `DEB_N`-th consecutive consistent `sample_en`.
- `fan_pwm` is registered: it reflects the new `fan_state` one clock later.
- `alarm` is registered: it asserts on the edge of the `ALARM_N`-th HIGH sample. That count includes the sample on which `fan_state` becomes HIGH? No: counting starts at the first `sample_en` after entry.
- `alarm_clr` takes effect on the next edge.
- `sample_en` on consecutive cycles is legal; every strobed cycle counts.
- Inputs are synchronous to `clk`. No metastability handling inside the block.

## Structure
- Shared package `ventilador_pkg`: state constants `ST_OFF` = 2'd0, `ST_LOW` = 2'd1, `ST_HIGH` = 2'd2, and the decode function from flags to target level.
- One sub-module, `pwm_gen`: counter plus duty compare, parameterised by `PWM_BITS`. Inputs: `clk`, `rst_n`, 2-bit level, duty value. Output: registered PWM.
- Debounce FSM and alarm logic live in the top module.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles with flags 11 → all outputs 0. After release, outputs stay 0 until 4 strobes.
- Debounce rise: flags 10 for 4 strobes → `fan_state` = 1 on the 4th strobe edge. `fan_pwm` then shows 8 clocks high, 8 clocks low per 16-clock period.
- Glitch rejection: flags 10, 10, 10, 00, 10, 10, 10, 10 (strobed) → `fan_state` goes to 1 only on the 8th strobe.
- Direct jump and alarm: flags 11 for 4 strobes → `fan_state` = 2 and `fan_pwm` constant 1. After 16 further strobes → `alarm` = 1. Flags 00 for 4 strobes → `fan_state` = 0, `alarm` remains 1.
- Clear priority: pulse `alarm_clr` on the same cycle as the 16th HIGH strobe → `alarm` stays 0. Counting restarts, and `alarm` sets after 16 more strobes.
- Illegal flags 01 for 4 strobes → `fan_state` = 2.

Source files
------------

// File: rtl/ventilador_pkg.sv
// Shared fan level encoding and the flag-to-level decode.
package ventilador_pkg;

    typedef logic [1:0] fan_level_t;

    localparam fan_level_t ST_OFF  = 2'd0;
    localparam fan_level_t ST_LOW  = 2'd1;
    localparam fan_level_t ST_HIGH = 2'd2;

    // mayor28 dominates; the inconsistent 01 combination is treated as hot.
    function automatic fan_level_t decode_target(input logic mayor25, input logic mayor28);
        if (mayor28) begin
            return ST_HIGH;
        end
        if (mayor25) begin
            return ST_LOW;
        end
        return ST_OFF;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a per-level duty compare and registered output.
module pwm_gen
    import ventilador_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          level,
    input  logic [PWM_BITS:0]   duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm_d;
    logic                pwm_q;

    // Output level decode; duty is one bit wider so a full-period duty reads as constant 1.
    always_comb begin
        pwm_d = 1'b0;
        case (level)
            ST_LOW:  pwm_d = ({1'b0, cnt_q} < duty);
            ST_HIGH: pwm_d = 1'b1;
            default: pwm_d = 1'b0;
        endcase
    end

    // Period counter wraps naturally; output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/control_ventilador.sv
// Fan controller: debounced level selection, sticky over-temperature alarm and PWM drive.
module control_ventilador
    import ventilador_pkg::*;
#(
    parameter int unsigned DEB_N    = 4,
    parameter int unsigned ALARM_N  = 16,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DUTY_LOW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       mayor25,
    input  logic       mayor28,
    input  logic       alarm_clr,
    output logic [1:0] fan_state,
    output logic       fan_pwm,
    output logic       alarm
);

    fan_level_t state_q, state_d;
    fan_level_t cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    fan_level_t target;

    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       alarm_q, alarm_d;

    assign target = decode_target(mayor25, mayor28);

    // Level state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Debounce next-state: a level change needs DEB_N consecutive strobes agreeing on it.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q;
        if (sample_en) begin
            if (target == state_q) begin
                cnt_d = 4'd0;
            end else begin
                if (target == cand_q) begin
                    cnt_inc = cnt_q + 4'd1;
                end else begin
                    cand_d  = target;
                    cnt_inc = 4'd1;
                end
                if (cnt_inc == 4'(DEB_N)) begin
                    state_d = target;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    // Debounce candidate and agreement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= ST_OFF;
            cnt_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output decode of the level FSM.
    always_comb begin
        fan_state = state_q;
    end

    // Alarm: count strobes spent in HIGH (entry strobe excluded); clear has priority.
    always_comb begin
        alarm_cnt_d = alarm_cnt_q;
        alarm_d     = alarm_q;
        if (sample_en) begin
            if (state_q == ST_HIGH && state_d == ST_HIGH) begin
                if (alarm_cnt_q < 8'(ALARM_N)) begin
                    alarm_cnt_d = alarm_cnt_q + 8'd1;
                    if (alarm_cnt_q + 8'd1 == 8'(ALARM_N)) begin
                        alarm_d = 1'b1;
                    end
                end
            end else begin
                alarm_cnt_d = 8'd0;
            end
        end
        if (alarm_clr) begin
            alarm_cnt_d = 8'd0;
            alarm_d     = 1'b0;
        end
    end

    // Alarm counter and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt_q <= 8'd0;
            alarm_q     <= 1'b0;
        end else begin
            alarm_cnt_q <= alarm_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign alarm = alarm_q;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .level (state_q),
        .duty  ((PWM_BITS + 1)'(DUTY_LOW)),
        .pwm   (fan_pwm)
    );

endmodule
